alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu.sv | 24 ++
 rtl/alu_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the two-requester ALU arbiter.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  localparam int OPS_DONE_W = 8;

endpackage

// File: rtl/alu.sv
// Combinational ALU: add/sub wrap modulo 2^WIDTH, plus bitwise AND/OR.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] res
);

  always_comb begin
    res = '0;
    case (alu_op_e'(sel))
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter in front of a shared ALU; holds one result until the
// consumer takes it, then counts the completed response.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [WIDTH-1:0]      req0_a,
  input  logic [WIDTH-1:0]      req0_b,
  input  logic [1:0]            req0_sel,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [WIDTH-1:0]      req1_a,
  input  logic [WIDTH-1:0]      req1_b,
  input  logic [1:0]            req1_sel,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_res,
  output logic                  rsp_id,
  output logic [OPS_DONE_W-1:0] ops_done
);

  state_e                  state_reg;
  logic                    ptr_reg;
  logic [WIDTH-1:0]        rsp_res_reg;
  logic                    rsp_id_reg;
  logic [OPS_DONE_W-1:0]   ops_done_reg;

  logic                    grant_valid;
  logic                    winner;
  logic [WIDTH-1:0]        mux_a;
  logic [WIDTH-1:0]        mux_b;
  logic [1:0]              mux_sel;
  logic [WIDTH-1:0]        alu_res;

  // Grant is purely combinational from this cycle's valids; nothing is
  // remembered about a requester that drops valid before being accepted.
  always_comb begin
    winner = 1'b0;
    if (req0_valid && req1_valid) begin
      winner = ptr_reg;
    end else if (req1_valid) begin
      winner = 1'b1;
    end
    grant_valid = (state_reg == IDLE) && (req0_valid || req1_valid) && !reset;
  end

  assign req0_ready = grant_valid && !winner;
  assign req1_ready = grant_valid &&  winner;

  assign mux_a   = winner ? req1_a   : req0_a;
  assign mux_b   = winner ? req1_b   : req0_b;
  assign mux_sel = winner ? req1_sel : req0_sel;

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a   (mux_a),
    .b   (mux_b),
    .sel (mux_sel),
    .res (alu_res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      ptr_reg      <= 1'b0;
      rsp_res_reg  <= '0;
      rsp_id_reg   <= 1'b0;
      ops_done_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            rsp_res_reg <= alu_res;
            rsp_id_reg  <= winner;
            ptr_reg     <= ~winner;
            state_reg   <= RESP;
          end
        end
        RESP: begin
          // Returning to IDLE costs a cycle, so no accept overlaps this handshake.
          if (rsp_ready) begin
            ops_done_reg <= ops_done_reg + 1'b1;
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (state_reg == RESP);
  assign rsp_res   = rsp_res_reg;
  assign rsp_id    = rsp_id_reg;
  assign ops_done  = ops_done_reg;

endmodule
